ex_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit attached to the execute stage, alongside the single-cycle ALU and shifter. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO operations from the decoded instruction and computes products and quotients one bit per cycle into architectural HI/LO registers. It raises a stall to the pipeline while a result is pending and either a new mul/div or a HI/LO read arrives.

---
 rtl/ex_muldiv_unit.sv | 224 ++++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative multiply/divide unit for the execute stage.
// Multiply is shift-add on a 2*XLEN accumulator. Divide is restoring division.
// Both work on operand magnitudes, one bit per cycle, and produce XLEN-bit
// HI/LO results. A one-cycle FIX state applies the sign correction and
// handles divide-by-zero before HI/LO are written.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hilo_rd,
  input  logic            flush,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic            dz,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(XLEN - 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0]     r_cnt;
  logic [2*XLEN-1:0] r_acc;       // mul: {partial sum, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   r_opnd;      // mul: multiplicand magnitude; div: divisor magnitude
  logic [XLEN-1:0]   r_a_orig;    // original dividend, returned in HI on divide-by-zero
  logic              r_is_div;
  logic              r_sign_a;
  logic              r_sign_b;
  logic              r_bzero;
  logic              r_done;
  logic              r_dz;
  logic [XLEN-1:0]   r_hi;
  logic [XLEN-1:0]   r_lo;

  // Decode of the request presented this cycle
  logic            w_op_muldiv;
  logic            w_op_is_div;
  logic            w_op_signed;
  logic            w_sign_a;
  logic            w_sign_b;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_accept;
  logic            w_idle;

  // One iteration of the datapath
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_shift;
  logic [XLEN-1:0]   w_div_diff;
  logic              w_div_ge;
  logic [2*XLEN-1:0] w_acc_step;

  // Sign-corrected results produced in FIX
  logic              w_neg_res;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_res_hi;
  logic [XLEN-1:0]   w_res_lo;

  // Request decode: magnitudes and signs are only taken for the signed ops
  always_comb begin
    w_idle      = (r_state == S_IDLE);
    w_op_muldiv = start && ((op == OP_MULT) || (op == OP_MULTU) ||
                            (op == OP_DIV)  || (op == OP_DIVU));
    w_op_is_div = (op == OP_DIV) || (op == OP_DIVU);
    w_op_signed = (op == OP_MULT) || (op == OP_DIV);
    w_sign_a    = w_op_signed && a[XLEN-1];
    w_sign_b    = w_op_signed && b[XLEN-1];
    w_abs_a     = w_sign_a ? (~a + 1'b1) : a;
    w_abs_b     = w_sign_b ? (~b + 1'b1) : b;
    w_accept    = w_idle && w_op_muldiv && !flush;
  end

  // Single iteration step for shift-add multiply and restoring divide
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_div_shift = r_acc[2*XLEN-1:XLEN-1];
    w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
    // When the trial subtract succeeds the difference is below the divisor,
    // so the low XLEN bits of the subtraction are the whole new remainder.
    w_div_diff  = w_div_shift[XLEN-1:0] - r_opnd;
    if (r_is_div) begin
      w_acc_step = {(w_div_ge ? w_div_diff : w_div_shift[XLEN-1:0]),
                    r_acc[XLEN-2:0], w_div_ge};
    end else begin
      w_acc_step = {w_mul_sum, r_acc[XLEN-1:1]};
    end
  end

  // Sign fix-up and divide-by-zero override applied at the FIX edge
  always_comb begin
    w_neg_res = r_sign_a ^ r_sign_b;
    w_prod    = w_neg_res ? (~r_acc + 1'b1) : r_acc;
    w_quo     = w_neg_res ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
    w_rem     = r_sign_a ? (~r_acc[2*XLEN-1:XLEN] + 1'b1) : r_acc[2*XLEN-1:XLEN];
    if (!r_is_div) begin
      w_res_hi = w_prod[2*XLEN-1:XLEN];
      w_res_lo = w_prod[XLEN-1:0];
    end else if (r_bzero) begin
      w_res_hi = r_a_orig;
      w_res_lo = '1;
    end else begin
      w_res_hi = w_rem;
      w_res_lo = w_quo;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic; flush wins over everything else
  always_comb begin
    w_state_next = r_state;
    if (flush) begin
      w_state_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE:  if (w_op_muldiv) w_state_next = S_RUN;
        S_RUN:   if (r_cnt == LAST_ITER) w_state_next = S_FIX;
        S_FIX:   w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Outputs: busy and stall are combinational, the rest come from registers
  always_comb begin
    busy  = (r_state != S_IDLE);
    stall = busy && (start || hilo_rd);
    done  = r_done;
    dz    = r_dz;
    hi    = r_hi;
    lo    = r_lo;
  end

  // Iteration counter: cleared on accept or flush, advances once per RUN edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (flush || w_accept) begin
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Operand capture on accept, then one accumulator step per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc    <= '0;
      r_opnd   <= '0;
      r_a_orig <= '0;
      r_is_div <= 1'b0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_bzero  <= 1'b0;
    end else if (w_accept) begin
      r_acc    <= {{XLEN{1'b0}}, (w_op_is_div ? w_abs_a : w_abs_b)};
      r_opnd   <= w_op_is_div ? w_abs_b : w_abs_a;
      r_a_orig <= a;
      r_is_div <= w_op_is_div;
      r_sign_a <= w_sign_a;
      r_sign_b <= w_sign_b;
      r_bzero  <= (b == '0);
    end else if ((r_state == S_RUN) && !flush) begin
      r_acc    <= w_acc_step;
    end
  end

  // HI/LO: result write at the FIX edge, direct MTHI/MTLO writes when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (!flush) begin
      if (r_state == S_FIX) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end else if (w_idle && start && (op == OP_MTHI)) begin
        r_hi <= a;
      end else if (w_idle && start && (op == OP_MTLO)) begin
        r_lo <= a;
      end
    end
  end

  // Completion pulse and divide-by-zero flag, one cycle after the FIX edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_done <= 1'b0;
      r_dz   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX) && !flush;
      r_dz   <= (r_state == S_FIX) && !flush && r_is_div && r_bzero;
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: randomized and directed checks of ex_muldiv_unit at
// XLEN=32 and XLEN=8 against a plain-arithmetic reference model.
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, hilo_rd, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, stall, done, dz;
  logic [31:0] hi, lo;

  logic        s8_start, s8_hilo_rd, s8_flush;
  logic [2:0]  s8_op;
  logic [7:0]  s8_a, s8_b;
  logic        s8_busy, s8_stall, s8_done, s8_dz;
  logic [7:0]  s8_hi, s8_lo;

  int n_checks = 0;
  int n_fail   = 0;

  longint unsigned m_hi = 0, m_lo = 0, m8_hi = 0, m8_lo = 0;

  ex_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hilo_rd(hilo_rd), .flush(flush), .busy(busy), .stall(stall),
    .done(done), .dz(dz), .hi(hi), .lo(lo)
  );

  ex_muldiv_unit #(.XLEN(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8_start), .op(s8_op), .a(s8_a), .b(s8_b),
    .hilo_rd(s8_hilo_rd), .flush(s8_flush), .busy(s8_busy), .stall(s8_stall),
    .done(s8_done), .dz(s8_dz), .hi(s8_hi), .lo(s8_lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: architectural HI/LO effect of one operation at width w
  function automatic void model(input int w, input logic [2:0] o,
                                input longint unsigned x, input longint unsigned y,
                                inout longint unsigned mh, inout longint unsigned ml,
                                output bit mdz);
    longint unsigned mask = (64'd1 << w) - 1;
    longint sx, sy, q, r;
    longint unsigned pu;
    sx  = x[w-1] ? longint'(x) - longint'(mask) - 1 : longint'(x);
    sy  = y[w-1] ? longint'(y) - longint'(mask) - 1 : longint'(y);
    mdz = 1'b0;
    case (o)
      3'd1: begin q = sx * sy; mh = ($unsigned(q) >> w) & mask; ml = $unsigned(q) & mask; end
      3'd2: begin pu = x * y; mh = (pu >> w) & mask; ml = pu & mask; end
      3'd3: if (y == 0) begin mh = x; ml = mask; mdz = 1'b1; end
            else begin q = sx / sy; r = sx % sy; ml = $unsigned(q) & mask; mh = $unsigned(r) & mask; end
      3'd4: if (y == 0) begin mh = x; ml = mask; mdz = 1'b1; end
            else begin ml = x / y; mh = x % y; end
      3'd5: mh = x;
      3'd6: ml = x;
      default: ;
    endcase
  endfunction

  // One full operation on the 32-bit unit, checking timing and result
  task automatic op32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    bit mdz;
    int edges, bcnt;
    @(negedge clk); start = 1'b1; op = o; a = x; b = y;
    @(negedge clk); start = 1'b0; op = 3'd0;
    model(32, o, x, y, m_hi, m_lo, mdz);
    if (o == 3'd5 || o == 3'd6) begin
      check("mt_busy", busy, 0);
      check("mt_done", done, 0);
      check("mt_hi", hi, m_hi);
      check("mt_lo", lo, m_lo);
    end else begin
      edges = 0; bcnt = 0;
      while (!done && edges < 100) begin
        if (busy) bcnt++;
        @(negedge clk); edges++;
      end
      check("latency", edges, 33);
      check("busy_cycles", bcnt, 33);
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
      check("dz", dz, mdz);
    end
    $display("op32 op=%0d a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h dz=%0b", o, x, y, hi, lo, dz);
  endtask

  // Same for the 8-bit unit
  task automatic op8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    bit mdz;
    int edges;
    @(negedge clk); s8_start = 1'b1; s8_op = o; s8_a = x; s8_b = y;
    @(negedge clk); s8_start = 1'b0; s8_op = 3'd0;
    model(8, o, x, y, m8_hi, m8_lo, mdz);
    if (o == 3'd5 || o == 3'd6) begin
      check("mt8_busy", s8_busy, 0);
    end else begin
      edges = 0;
      while (!s8_done && edges < 100) begin @(negedge clk); edges++; end
      check("latency8", edges, 9);
      check("dz8", s8_dz, mdz);
    end
    check("hi8", s8_hi, m8_hi);
    check("lo8", s8_lo, m8_lo);
    $display("op8 op=%0d a=0x%02h b=0x%02h -> hi=0x%02h lo=0x%02h dz=%0b", o, x, y, s8_hi, s8_lo, s8_dz);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [31:0] old_hi, old_lo, rx, ry;
    logic [2:0]  ro;
    bit mdz;
    int k, seen;

    rst_n = 1'b0; start = 0; op = 0; a = 0; b = 0; hilo_rd = 0; flush = 0;
    s8_start = 0; s8_op = 0; s8_a = 0; s8_b = 0; s8_hilo_rd = 0; s8_flush = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_dz", dz, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    rst_n = 1'b1;

    // Directed values from the test plan
    op32(3'd1, 32'hFFFFFFFE, 32'd3);
    check("mult_hi_k", hi, 32'hFFFFFFFF); check("mult_lo_k", lo, 32'hFFFFFFFA);
    op32(3'd2, 32'hFFFFFFFE, 32'd3);
    check("multu_hi_k", hi, 32'h2); check("multu_lo_k", lo, 32'hFFFFFFFA);
    op32(3'd3, 32'hFFFFFFF9, 32'd2);
    check("div_lo_k", lo, 32'hFFFFFFFD); check("div_hi_k", hi, 32'hFFFFFFFF);
    op32(3'd4, 32'd100, 32'd7);
    check("divu_lo_k", lo, 32'd14); check("divu_hi_k", hi, 32'd2);
    op32(3'd3, 32'h80000000, 32'hFFFFFFFF);
    check("ovf_lo_k", lo, 32'h80000000); check("ovf_hi_k", hi, 32'h0);
    op32(3'd4, 32'h1234, 32'd0);
    check("dz_hi_k", hi, 32'h1234); check("dz_lo_k", lo, 32'hFFFFFFFF);
    op32(3'd3, 32'hFFFFFFFB, 32'd0);
    check("dzs_hi_k", hi, 32'hFFFFFFFB);
    op32(3'd6, 32'h5A, 32'd0);
    op32(3'd5, 32'hCAFE0001, 32'd0);

    // Stall: hilo_rd and a queued DIV during a MULT
    old_hi = 32'(m_hi); old_lo = 32'(m_lo);
    @(negedge clk); start = 1; op = 3'd1; a = 32'h12345678; b = 32'hFEDCBA98;
    @(negedge clk); start = 0; op = 0;
    model(32, 3'd1, 32'h12345678, 32'hFEDCBA98, m_hi, m_lo, mdz);
    repeat (9) @(negedge clk);
    hilo_rd = 1; #1;
    check("stall_hilo", stall, 1);
    check("hold_hi", hi, old_hi);
    check("hold_lo", lo, old_lo);
    @(negedge clk); hilo_rd = 0; start = 1; op = 3'd3; a = 32'd1000; b = 32'hFFFFFFF9;
    #1 check("stall_start", stall, 1);
    k = 0;
    while (!done && k < 100) begin @(negedge clk); k++; end
    check("stall_mul_hi", hi, m_hi);
    check("stall_mul_lo", lo, m_lo);
    check("done_cycle_stall", stall, 0);
    @(negedge clk); start = 0; op = 0;
    check("accept_on_done", busy, 1);
    model(32, 3'd3, 32'd1000, 32'hFFFFFFF9, m_hi, m_lo, mdz);
    k = 0;
    while (!done && k < 100) begin @(negedge clk); k++; end
    check("queued_lat", k, 33);
    check("queued_hi", hi, m_hi);
    check("queued_lo", lo, m_lo);
    $display("stall test: div hi=0x%08h lo=0x%08h", hi, lo);

    // Flush mid-DIV: no result, no done
    @(negedge clk); start = 1; op = 3'd4; a = 32'd999; b = 32'd3;
    @(negedge clk); start = 0; op = 0;
    repeat (5) @(negedge clk);
    flush = 1;
    @(negedge clk); flush = 0;
    check("flush_busy", busy, 0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    check("flush_no_done", seen, 0);
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);
    $display("flush test: hi=0x%08h lo=0x%08h", hi, lo);

    // Asynchronous reset mid-MULT
    @(negedge clk); start = 1; op = 3'd1; a = 32'd77; b = 32'd55;
    @(negedge clk); start = 0; op = 0;
    repeat (4) @(negedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_dz", dz, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    m_hi = 0; m_lo = 0; m8_hi = 0; m8_lo = 0;
    @(negedge clk); rst_n = 1;
    $display("reset test: hi=0x%08h lo=0x%08h busy=%0b", hi, lo, busy);

    // Randomized 32-bit operations
    repeat (25) begin
      ro = 3'($urandom_range(1, 6));
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 3) == 0) ry = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) ry = 32'd0;
      if ($urandom_range(0, 9) == 0) begin rx = 32'h80000000; ry = 32'hFFFFFFFF; end
      op32(ro, rx, ry);
    end

    // 8-bit unit
    op8(3'd1, 8'h80, 8'h80);
    check("mult8_hi_k", s8_hi, 8'h40); check("mult8_lo_k", s8_lo, 8'h00);
    op8(3'd6, 8'h5A, 8'h00);
    check("mtlo8_k", s8_lo, 8'h5A);
    repeat (12) begin
      ro = 3'($urandom_range(1, 6));
      rx = $urandom;
      ry = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      op8(ro, rx[7:0], ry[7:0]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
